// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Sits behind the EX/MEM register. It turns one M-stage load or store into a
// single req/ack bus cycle with byte enables. It stalls the pipeline until the
// access completes, then returns aligned and extended load data.
// Misaligned accesses and illegal funct3 codes are flagged and suppressed.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   aluResultM       effective byte address
//   writeDataM       store data (low bits significant)
//   memWriteM        store request (wins over a load)
//   resultSrcM       load when equal to LOAD_SRC
//   addressingmodeM  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   holdM            downstream stall; EX/MEM contents are held
//   memStall         stall request to the hazard unit
//   readDataM        extended load result, held until the next load
//   misalignM        misaligned / illegal access flag (IDLE only)
//   bus_*            word-wide request/acknowledge data bus
//
// state | meaning
// IDLE  | waiting for an M-stage access; faults are flagged here
// BUSY  | bus_req high, bus fields frozen, waiting for bus_ack
// DONE  | access finished, readDataM valid, waiting for holdM to drop
module mem_stage_lsu #(
  parameter logic [1:0] LOAD_SRC = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluResultM,
  input  logic [31:0] writeDataM,
  input  logic        memWriteM,
  input  logic [1:0]  resultSrcM,
  input  logic [2:0]  addressingmodeM,
  input  logic        holdM,
  output logic        memStall,
  output logic [31:0] readDataM,
  output logic        misalignM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_bus_req, r_bus_we;
  logic [31:0] r_bus_addr, r_bus_wdata, r_read_data;
  logic [3:0]  r_bus_be;
  logic [1:0]  r_off;
  logic [2:0]  r_mode;

  logic        w_access, w_fault, w_start, w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_extract;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_access = memWriteM | (resultSrcM == LOAD_SRC);

  always_comb begin
    w_fault = 1'b0;
    case (addressingmodeM)
      3'b001, 3'b101:         w_fault = aluResultM[0];
      3'b010:                 w_fault = |aluResultM[1:0];
      3'b011, 3'b110, 3'b111: w_fault = 1'b1;
      default:                w_fault = 1'b0;
    endcase
    w_fault = w_fault & w_access;
  end

  assign w_start = w_access & ~w_fault;

  // Loads always fetch the full word; lane selection happens on return.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = writeDataM;
    case (addressingmodeM[1:0])
      2'b00: begin
        w_wdata = {4{writeDataM[7:0]}};
        if (memWriteM) w_be = 4'b0001 << aluResultM[1:0];
      end
      2'b01: begin
        w_wdata = {2{writeDataM[15:0]}};
        if (memWriteM) w_be = 4'b0011 << aluResultM[1:0];
      end
      default: begin
        w_wdata = writeDataM;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Lane extraction uses the offset and mode captured at issue time.
  always_comb begin
    w_byte    = bus_rdata[{r_off, 3'b000} +: 8];
    w_half    = bus_rdata[{r_off[1], 4'b0000} +: 16];
    w_extract = bus_rdata;
    case (r_mode)
      3'b000:  w_extract = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_extract = {{16{w_half[15]}}, w_half};
      3'b100:  w_extract = {24'h0, w_byte};
      3'b101:  w_extract = {16'h0, w_half};
      default: w_extract = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_stall     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (bus_ack) w_state_nxt = DONE;
      end
      DONE: begin
        if (!holdM) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_bus_be    <= 4'h0;
      r_read_data <= 32'h0;
      r_off       <= 2'b00;
      r_mode      <= 3'b000;
    end else if (r_state == IDLE) begin
      if (w_start) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= memWriteM;
        r_bus_addr  <= {aluResultM[31:2], 2'b00};
        r_bus_wdata <= w_wdata;
        r_bus_be    <= w_be;
        r_off       <= aluResultM[1:0];
        r_mode      <= addressingmodeM;
      end
    end else if (r_state == BUSY) begin
      if (bus_ack) begin
        r_bus_req <= 1'b0;
        if (!r_bus_we) r_read_data <= w_extract;
      end
    end
  end

  assign memStall  = w_stall;
  assign misalignM = w_fault & (r_state == IDLE);
  assign readDataM = r_read_data;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expected values.
module tb_mem_stage_lsu;

  localparam logic [1:0] LS = 2'b01;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluResultM, writeDataM, bus_rdata;
  logic        memWriteM, holdM, bus_ack;
  logic [1:0]  resultSrcM;
  logic [2:0]  addressingmodeM;
  logic        memStall, misalignM, bus_req, bus_we;
  logic [31:0] readDataM, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int n_pass  = 0;
  int n_total = 0;
  int stall_cycles;

  mem_stage_lsu #(.LOAD_SRC(LS)) dut (
    .clk(clk), .rst(rst),
    .aluResultM(aluResultM), .writeDataM(writeDataM), .memWriteM(memWriteM),
    .resultSrcM(resultSrcM), .addressingmodeM(addressingmodeM), .holdM(holdM),
    .memStall(memStall), .readDataM(readDataM), .misalignM(misalignM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic ld, input logic [2:0] mode);
    aluResultM      = a;
    writeDataM      = wd;
    memWriteM       = we;
    resultSrcM      = ld ? LS : 2'b00;
    addressingmodeM = mode;
    #1;
  endtask

  task automatic idle_inputs();
    memWriteM  = 1'b0;
    resultSrcM = 2'b00;
  endtask

  // Issue a load with an immediate ack; returns in the DONE cycle.
  task automatic run_load(input logic [31:0] a, input logic [2:0] mode, input logic [31:0] rd);
    present(a, 32'h0, 1'b0, 1'b1, mode);
    step();
    bus_ack   = 1'b1;
    bus_rdata = rd;
    step();
    bus_ack = 1'b0;
    idle_inputs();
    #1;
  endtask

  initial begin
    rst = 1'b1; holdM = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    aluResultM = 32'h0; writeDataM = 32'h0; memWriteM = 1'b0;
    resultSrcM = 2'b00; addressingmodeM = 3'b000;
    #12;
    chk("rst_stall", {31'b0, memStall}, 32'd0);
    chk("rst_misalign", {31'b0, misalignM}, 32'd0);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_rdata", readDataM, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", {28'b0, bus_be}, 32'h0);
    rst = 1'b0;
    step();

    // LW 0x1000, ack two cycles after req
    stall_cycles = 0;
    present(32'h1000, 32'h0, 1'b0, 1'b1, 3'b010);
    if (memStall) stall_cycles++;
    step();
    chk("lw_req", {31'b0, bus_req}, 32'd1);
    chk("lw_addr", bus_addr, 32'h1000);
    chk("lw_be", {28'b0, bus_be}, 32'hF);
    chk("lw_we", {31'b0, bus_we}, 32'd0);
    present(32'h5555_0000, 32'h0, 1'b0, 1'b1, 3'b000);
    if (memStall) stall_cycles++;
    step();
    chk("lw_addr_held", bus_addr, 32'h1000);
    if (memStall) stall_cycles++;
    step();
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    if (memStall) stall_cycles++;
    step();
    bus_ack = 1'b0; idle_inputs();
    #1;
    chk("lw_stall_cycles", stall_cycles, 32'd4);
    chk("lw_done_stall", {31'b0, memStall}, 32'd0);
    chk("lw_done_req", {31'b0, bus_req}, 32'd0);
    chk("lw_rdata", readDataM, 32'hDEAD_BEEF);
    step();
    chk("lw_idle_stall", {31'b0, memStall}, 32'd0);

    // SB 0x2003
    present(32'h2003, 32'h0000_00A5, 1'b1, 1'b0, 3'b000);
    chk("sb_stall", {31'b0, memStall}, 32'd1);
    step();
    chk("sb_be", {28'b0, bus_be}, 32'h8);
    chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
    chk("sb_we", {31'b0, bus_we}, 32'd1);
    chk("sb_addr", bus_addr, 32'h2000);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0; idle_inputs();
    #1;
    chk("sb_rdata_kept", readDataM, 32'hDEAD_BEEF);
    step();

    // SH 0x4002
    present(32'h4002, 32'h1234_BEEF, 1'b1, 1'b0, 3'b001);
    step();
    chk("sh_be", {28'b0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0; idle_inputs();
    step();

    // Sub-word load extraction, rdata 0x0080FF00
    run_load(32'h3002, 3'b000, 32'h0080_FF00);
    chk("lb_3002", readDataM, 32'hFFFF_FF80);
    step();
    run_load(32'h3002, 3'b100, 32'h0080_FF00);
    chk("lbu_3002", readDataM, 32'h0000_0080);
    step();
    run_load(32'h3002, 3'b001, 32'h0080_FF00);
    chk("lh_3002", readDataM, 32'h0000_0080);
    step();
    run_load(32'h3000, 3'b001, 32'h0080_FF00);
    chk("lh_3000", readDataM, 32'hFFFF_FF00);
    step();
    run_load(32'h3000, 3'b101, 32'h0080_FF00);
    chk("lhu_3000", readDataM, 32'h0000_FF00);
    step();
    run_load(32'h3001, 3'b000, 32'h0080_FF00);
    chk("lb_3001", readDataM, 32'hFFFF_FFFF);
    step();

    // Faulting accesses
    present(32'h1001, 32'h0, 1'b0, 1'b1, 3'b010);
    chk("lw_mis_flag", {31'b0, misalignM}, 32'd1);
    chk("lw_mis_stall", {31'b0, memStall}, 32'd0);
    step();
    chk("lw_mis_req", {31'b0, bus_req}, 32'd0);
    present(32'h1003, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b001);
    chk("sh_mis_flag", {31'b0, misalignM}, 32'd1);
    chk("sh_mis_stall", {31'b0, memStall}, 32'd0);
    step();
    chk("sh_mis_req", {31'b0, bus_req}, 32'd0);
    present(32'h1000, 32'h0, 1'b0, 1'b1, 3'b011);
    chk("m011_flag", {31'b0, misalignM}, 32'd1);
    chk("m011_stall", {31'b0, memStall}, 32'd0);
    step();
    chk("m011_req", {31'b0, bus_req}, 32'd0);
    chk("fault_rdata_kept", readDataM, 32'hFFFF_FFFF);
    present(32'h1002, 32'h0, 1'b0, 1'b1, 3'b001);
    chk("lh_aligned_noflag", {31'b0, misalignM}, 32'd0);
    idle_inputs();
    #1;
    chk("nofault_idle", {31'b0, misalignM}, 32'd0);

    // Load completing while holdM is high
    present(32'h5000, 32'h0, 1'b0, 1'b1, 3'b010);
    holdM = 1'b1;
    step();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ack = 1'b0;
    #1;
    chk("hold_rdata", readDataM, 32'hCAFE_F00D);
    chk("hold_st1", 32'(dut.r_state), 32'd2);
    step();
    chk("hold_st2", 32'(dut.r_state), 32'd2);
    chk("hold_req2", {31'b0, bus_req}, 32'd0);
    chk("hold_stall2", {31'b0, memStall}, 32'd0);
    step();
    chk("hold_st3", 32'(dut.r_state), 32'd2);
    chk("hold_req3", {31'b0, bus_req}, 32'd0);
    holdM = 1'b0; idle_inputs();
    step();
    chk("hold_release_st", 32'(dut.r_state), 32'd0);
    chk("hold_release_req", {31'b0, bus_req}, 32'd0);

    // Reset in the middle of BUSY
    present(32'h6000, 32'h0, 1'b0, 1'b1, 3'b010);
    step();
    chk("rb_req", {31'b0, bus_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rb_req_drop", {31'b0, bus_req}, 32'd0);
    chk("rb_state", 32'(dut.r_state), 32'd0);
    chk("rb_rdata", readDataM, 32'h0);
    idle_inputs();
    #1;
    rst = 1'b0;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_ack = 1'b0;
    #1;
    chk("rb_late_ack_rdata", readDataM, 32'h0);
    chk("rb_late_ack_req", {31'b0, bus_req}, 32'd0);
    chk("rb_late_ack_state", 32'(dut.r_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It sits directly downstream of the EX/MEM pipeline register and consumes its M-stage outputs: aluResultM, writeDataM, memWriteM, resultSrcM and addressingmodeM.
- Drives a word-wide req/ack data bus with byte enables, holds the pipeline via memStall until the access completes, and returns aligned, sign- or zero-extended load data to the MEM/WB register.
- Detects misaligned and illegal accesses and suppresses them.

Parameters:
- LOAD_SRC, 2'b01: resultSrcM encoding that marks a load.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- aluResultM  in  32  effective byte address
- writeDataM  in  32  store data; low bits are significant
- memWriteM  in  1  store request
- resultSrcM  in  2  load when equal to LOAD_SRC
- addressingmodeM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- holdM  in  1  downstream stall from the hazard unit; the EX/MEM contents are held
- memStall  out  1  to the hazard unit; stalls IF/ID/EX and EX/MEM
- readDataM  out  32  extended load result
- misalignM  out  1  misaligned or illegal access flag
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address; bits [1:0] are always 00
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_rdata  in  32  read word; valid when bus_ack is high
- bus_ack  in  1  one-cycle completion

Behaviour:
- access = memWriteM | (resultSrcM == LOAD_SRC). memWriteM takes priority if both are set.
- Fault (combinational): fault = access & (H/HU with addr[0]=1, or W with addr[1:0]≠0, or addressingmodeM ∈ {011, 110, 111}).
- misalignM = fault & (state == IDLE).
- A faulting access generates no bus cycle and no stall, and leaves readDataM unchanged. The faulting store is dropped.
- FSM states: IDLE, BUSY, DONE.
- IDLE, access & !fault:
  - Register bus_addr = {addr[31:2], 2'b00} and bus_we = memWriteM.
  - Register bus_be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW and all loads 1111.
  - Register bus_wdata: SB {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW wd.
  - Set bus_req <= 1 and go to BUSY.
  - memStall = 1 combinationally in this same cycle.
- BUSY:
  - memStall = 1; bus_* fields are held stable.
  - On bus_ack: bus_req <= 0 and go to DONE.
  - If the access is a load, register readDataM <= extract(bus_rdata, addr[1:0], mode) in the same edge.
  - Without bus_ack, remain in BUSY indefinitely; there is no timeout.
- extract:
  - Bytes: lane addr[1:0], i.e. rdata[8*a+7 : 8*a].
  - Halves: lane addr[1], i.e. rdata[16*h+15 : 16*h].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- DONE:
  - memStall = 0; readDataM is valid.
  - If holdM = 1, stay in DONE; the same instruction is never re-issued.
  - If holdM = 0, go to IDLE.
- Minimum access latency: 3 cycles (IDLE, BUSY with ack on the first cycle, DONE). Each extra ack wait adds one BUSY cycle.
- bus_ack outside BUSY is ignored.
- Address and data are captured in IDLE. Any change on the M-stage inputs during BUSY/DONE is ignored.
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, readDataM 0.
- Combinational outputs out of reset: memStall and misalignM are 0 while no access is presented.
- Reset mid-BUSY abandons the transaction and drops bus_req asynchronously; a late ack is ignored.
- readDataM holds its last load value across stores and idle cycles.

Test Plan:
- LW, addr 0x1000; ack 2 cycles after req with rdata 0xDEADBEEF:
  - bus_addr 0x1000, be 1111, we 0.
  - memStall high for 4 cycles.
  - readDataM = 0xDEADBEEF in DONE.
- SB, addr 0x2003, writeData 0x000000A5:
  - be 1000, wdata 0xA5A5A5A5, we 1.
  - readDataM unchanged.
- LB at 0x3002 and LBU at 0x3002, rdata 0x0080FF00:
  - LB gives 0xFFFFFF80; LBU gives 0x00000080.
  - LH at 0x3002 gives 0x00000080.
- LW at 0x1001, then SH at 0x1003, then mode 011:
  - misalignM = 1, memStall = 0, bus_req never asserted.
- Load completes while holdM = 1 for 3 cycles:
  - FSM stays in DONE and bus_req stays 0 (no second request).
  - Returns to IDLE after holdM falls.
- rst asserted during BUSY, then ack pulsed:
  - bus_req drops immediately and state is IDLE.
  - The ack is ignored and readDataM = 0.
